fir_tf_stream: RTL
==================

# fir_tf_stream

Parametrised, streaming, transposed-form FIR filter with run-time programmable coefficients. It replaces the fixed 10-tap, fixed-coefficient, parallel-input filter. It takes one unsigned sample per valid cycle and produces one filtered sample per accepted input. It sits in the DSP datapath between the sample source and the downstream accumulator/decimator.

## Interface
Parameters:
- DATA_W, 8: unsigned input sample width.
- COEF_W, 8: unsigned coefficient width.
- TAPS, 10: number of taps, ≥2.
- OUT_W, 16: output width.

Ports:
- clk, in, 1: single clock, all logic on rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- in_valid, in, 1: in_data is a new sample this cycle. No backpressure.
- in_data, in, DATA_W: input sample x[n].
- clr, in, 1: synchronous clear of the delay line and the output.
- coef_we, in, 1: coefficient write strobe.
- coef_addr, in, $clog2(TAPS): tap index k.
- coef_data, in, COEF_W: value written to h[k].
- out_valid, out, 1: out_data holds y[n]. Pulses one cycle per accepted sample.
- out_data, out, OUT_W: filtered sample.
- out_sat, out, 1: y[n] was saturated. Tied 0 when the saturation feature is not compiled in.

## Operation
- Function: y[n] = Σ h[k]·x[n−k], for k = 0..TAPS−1. All arithmetic is unsigned.
- Transposed form with TAPS−1 partial-sum registers z[0..TAPS−2].
- On each in_valid cycle:
  - z[k] ← h[k+1]·x + z[k+1], for k < TAPS−2.
  - z[TAPS−2] ← h[TAPS−1]·x.
  - Output register ← h[0]·x + z[0].
- When in_valid = 0: all z and h hold their values, out_valid = 0, and out_data holds its last value.
- Widths:
  - Product width is DATA_W+COEF_W.
  - ACC_W = DATA_W+COEF_W+$clog2(TAPS). All z registers and sums are ACC_W wide, so no internal overflow is possible.
  - Without the saturation feature, out_data = acc[OUT_W−1:0] (modulo wrap).
- Coefficients:
  - TAPS registers, written when coef_we = 1.
  - If coef_addr ≥ TAPS, the write is ignored.
  - A written value takes effect for samples accepted on later cycles.
  - A coef_we in the same cycle as in_valid: that sample uses the old value.
- clr:
  - Zeroes z[], out_data and out_sat, and forces out_valid to 0.
  - An in_valid in the same cycle is dropped.
  - Coefficients are preserved.
  - A coef_we in the same cycle as clr is still performed.
- Reset (rst_n = 0 at a clock edge):
  - z[] = 0.
  - h[0] = 1 and h[k] = 0 for k ≥ 1, giving a pass-through filter.
  - out_valid = 0, out_data = 0, out_sat = 0.
  - Reset mid-stream discards all history.

## Timing
- Latency: y[n] appears with out_valid = 1 on the cycle after in_valid is sampled.
- Throughput: one sample per cycle. Back-to-back in_valid is supported.
- out_valid is a single-cycle pulse per accepted sample. It is never asserted during reset or on the cycle after clr.
- Coefficient write latency: one cycle. The new value is visible to a sample presented on the next cycle.

## Configuration
- FIR_SAT_EN defined:
  - If acc > 2^OUT_W−1, out_data = 2^OUT_W−1 and out_sat = 1 for that sample.
  - Otherwise out_sat = 0.
- FIR_SAT_EN undefined:
  - out_data is truncated to the low OUT_W bits.
  - out_sat is constant 0.

## Structure
- A shared package fir_pkg holds:
  - The ACC_W computation function.
  - The reset-coefficient constant function (h[0] = 1).
  - The coefficient-address width helper.
- One sub-module: fir_tap. It holds one coefficient register plus multiply-add plus partial-sum register, and is instantiated TAPS−1 times in a generate loop. Tap 0 feeds the output register directly.

## Test plan
All scenarios use default parameters.
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1, in_data = 0xFF → out_valid = 0, out_data = 0, out_sat = 0 throughout.
- Default pass-through: after reset, feed samples 5, 7, 0 → out_data = 5, 7, 0, each one cycle after its input, with out_valid pulsing.
- Impulse response: write h[k] = k+1 for k = 0..9, then feed 1 followed by nine 0s → out_data = 1, 2, …, 10. Insert random in_valid gaps → same sequence, with out_valid only on accepted cycles.
- Overflow with all h = 255 and ten inputs of 255 (acc = 650250):
  - With FIR_SAT_EN → out_data = 65535, out_sat = 1.
  - Without FIR_SAT_EN → out_data = 60426, out_sat = 0.
- Simultaneous coefficient write: coef_we (h[0] = 3) in the same cycle as in_valid (x = 4) → output 4. The next sample x = 4 → output 12.
- clr mid-stream: with taps loaded as in the impulse test, assert clr after 3 samples with in_valid = 1 → no output for that cycle. The next impulse restarts at 1, 2, 3…

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared width helpers and reset-coefficient function for the transposed-form FIR
package fir_pkg;

    // Coefficient address width; a single tap still needs one address bit
    function automatic int addr_w(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    // Accumulator width large enough that the sum of TAPS full-scale products never overflows
    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Power-up coefficients form a pass-through filter: h[0] = 1, all others 0
    function automatic int rst_coef(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

endpackage

// File: rtl/fir_tap.sv
// fir_tap: one transposed-form tap (coefficient register, multiply-add, partial-sum register)
module fir_tap
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 20,
    parameter int ADDR_W = 4,
    parameter int IDX    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              coef_we,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    input  logic [ACC_W-1:0]  z_in,
    output logic [ACC_W-1:0]  z_out
);

    localparam int P_W = DATA_W + COEF_W;
    localparam logic [COEF_W-1:0] H_RST = COEF_W'(rst_coef(IDX));

    logic [COEF_W-1:0] h_q, h_d;
    logic [ACC_W-1:0]  z_q, z_d;
    logic [P_W-1:0]    prod;

    // Coefficient write and partial-sum update; the sample always sees the pre-write coefficient
    always_comb begin
        prod = {{COEF_W{1'b0}}, in_data} * {{DATA_W{1'b0}}, h_q};
        h_d  = (coef_we && coef_addr == ADDR_W'(IDX)) ? coef_data : h_q;
        z_d  = clr ? '0 : in_valid ? ACC_W'(prod) + z_in : z_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q <= H_RST;
            z_q <= '0;
        end else begin
            h_q <= h_d;
            z_q <= z_d;
        end
    end

    assign z_out = z_q;

endmodule

// File: rtl/fir_tf_stream.sv
// fir_tf_stream: streaming transposed-form FIR with programmable coefficients; optional saturation via FIR_SAT_EN
module fir_tf_stream
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 10,
    parameter int OUT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    clr,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]       coef_data,
    output logic                    out_valid,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_sat
);

    localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
    localparam int ADDR_W = $clog2(TAPS);
    localparam int P_W    = DATA_W + COEF_W;
    localparam logic [COEF_W-1:0] H0_RST = COEF_W'(rst_coef(0));
`ifdef FIR_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic [ACC_W-1:0]  zc [TAPS];
    logic [COEF_W-1:0] h0_q, h0_d;
    logic [P_W-1:0]    prod0;
    logic [ACC_W-1:0]  acc;
    logic              ovf, sat;
    logic [OUT_W-1:0]  y;
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_sat_q, out_sat_d;

    assign zc[TAPS-1] = '0;

    for (genvar k = 1; k < TAPS; k++) begin : g_tap
        fir_tap #(
            .DATA_W(DATA_W),
            .COEF_W(COEF_W),
            .ACC_W (ACC_W),
            .ADDR_W(ADDR_W),
            .IDX   (k)
        ) u_tap (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .in_valid (in_valid),
            .in_data  (in_data),
            .coef_we  (coef_we),
            .coef_addr(coef_addr),
            .coef_data(coef_data),
            .z_in     (zc[k]),
            .z_out    (zc[k-1])
        );
    end

    // Tap 0 multiply-add feeds the output register; clr drops a coincident sample
    always_comb begin
        prod0       = {{COEF_W{1'b0}}, in_data} * {{DATA_W{1'b0}}, h0_q};
        acc         = ACC_W'(prod0) + zc[0];
        ovf         = (acc >> OUT_W) != '0;
        sat         = SAT_EN && ovf;
        y           = sat ? '1 : OUT_W'(acc);
        h0_d        = (coef_we && coef_addr == '0) ? coef_data : h0_q;
        out_valid_d = in_valid && !clr;
        out_data_d  = clr ? '0 : in_valid ? y : out_data_q;
        out_sat_d   = clr ? 1'b0 : in_valid ? sat : out_sat_q;
    end

    // Tap 0 coefficient and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h0_q        <= H0_RST;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            h0_q        <= h0_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
